// File: rtl/beat_packer_if.sv
// Handshake bundle for beat_packer: upstream beat port (A__*) and downstream
// packed-word port (B__*). The slave modport is the packer's view.
interface beat_packer_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic           A__in_vld;
    logic [W-1:0]   A__in_w;
    logic           A__in_last;
    logic           A__stall_r;
    logic           B__out_vld_r;
    logic [N*W-1:0] B__out_r;
    logic [3:0]     B__out_cnt_r;
    logic           B__stall;

    modport slave (
        input  A__in_vld, A__in_w, A__in_last, B__stall,
        output A__stall_r, B__out_vld_r, B__out_r, B__out_cnt_r
    );

    modport master (
        output A__in_vld, A__in_w, A__in_last, B__stall,
        input  A__stall_r, B__out_vld_r, B__out_r, B__out_cnt_r
    );
endinterface

// File: rtl/beat_packer.sv
// Packs up to N W-bit beats into one N*W-bit word, LSB-first, with an early
// close on A__in_last, a one-word output slot and a one-word holding accumulator.
module beat_packer #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    beat_packer_if.slave  bus
);
    localparam logic [3:0] LAST_LANE = 4'(N - 1);

    logic [N*W-1:0] acc_q, acc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           acc_full_q, acc_full_d;
    logic [3:0]     hold_cnt_q, hold_cnt_d;
    logic [N*W-1:0] out_q, out_d;
    logic [3:0]     out_cnt_q, out_cnt_d;
    logic           out_vld_q, out_vld_d;

    logic           slot_free;
    logic           accept;
    logic           completes;
    logic [N*W-1:0] merged;

    assign slot_free = !out_vld_q || !bus.B__stall;
    assign accept    = bus.A__in_vld && !acc_full_q;
    assign completes = (cnt_q == LAST_LANE) || bus.A__in_last;

    always_comb begin
        merged = acc_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == 4'(k)) merged[k*W +: W] = bus.A__in_w;
        end
    end

    // The accumulator is cleared whenever a word leaves it, so unused upper
    // lanes of a short word are already zero without masking.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_full_d = acc_full_q;
        hold_cnt_d = hold_cnt_q;
        out_d      = out_q;
        out_cnt_d  = out_cnt_q;
        out_vld_d  = out_vld_q;

        if (out_vld_q && !bus.B__stall) out_vld_d = 1'b0;

        if (acc_full_q) begin
            if (slot_free) begin
                out_d      = acc_q;
                out_cnt_d  = hold_cnt_q;
                out_vld_d  = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
                acc_full_d = 1'b0;
            end
        end else if (accept) begin
            if (completes && slot_free) begin
                out_d     = merged;
                out_cnt_d = cnt_q + 4'd1;
                out_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else if (completes) begin
                acc_d      = merged;
                hold_cnt_d = cnt_q + 4'd1;
                acc_full_d = 1'b1;
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: the data registers are reset too, not just the control flops, so a
    // reset can never leak a stale partial word into a later output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            acc_full_q <= 1'b0;
            hold_cnt_q <= '0;
            out_q      <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            acc_full_q <= acc_full_d;
            hold_cnt_q <= hold_cnt_d;
            out_q      <= out_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.A__stall_r   = acc_full_q;
    assign bus.B__out_vld_r = out_vld_q;
    assign bus.B__out_r     = out_q;
    assign bus.B__out_cnt_r = out_cnt_q;
endmodule
